// File: rtl/motor_pkg.sv
// Shared types and constants for the motor driver: command encoding, the target table and channel states.
package motor_pkg;

  localparam int unsigned CMD_W  = 5;
  localparam int unsigned DUTY_W = 8;

  // Same one-hot encoding as the navigation FSM's motor_state bus
  typedef enum logic [CMD_W-1:0] {
    STOP    = 5'b00001,
    FORWARD = 5'b00010,
    RIGHT   = 5'b00100,
    LEFT    = 5'b01000,
    SPIN    = 5'b10000
  } motor_state_t;

  localparam int unsigned FULL_DUTY_DFLT = 200;
  localparam int unsigned TURN_DUTY_DFLT = 100;
  localparam int unsigned SPIN_DUTY_DFLT = 120;

  typedef enum logic [2:0] {IDLE, RAMP, RUN, BRAKE, DEAD} ch_state_t;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic              dir;
  } ch_target_t;

  function automatic logic is_onehot(input logic [CMD_W-1:0] v);
    return (v != '0) && ((v & (v - CMD_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One wheel: soft-start ramp, brake/dead-time direction reversal and glitch-free PWM comparator.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned RAMP_STEP     = 4,
  parameter int unsigned DEADTIME_CLKS = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  ch_target_t        tgt,
  input  logic              tick,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic              cnt_wrap,
  input  logic              force_stop,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic              pwm,
  output logic              active_c
);

  localparam int unsigned DEAD_W = (DEADTIME_CLKS > 1) ? $clog2(DEADTIME_CLKS) : 1;
  localparam logic [DUTY_W-1:0] STEP_MAX = DUTY_W'((RAMP_STEP > 255) ? 255 : RAMP_STEP);

  ch_state_t         state, state_nxt;
  logic [DUTY_W-1:0] duty_nxt, applied, goal_c, diff_c, step_c, slewed_c;
  logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
  logic              dir_nxt;

  // A pending reversal always slews toward zero first
  always_comb begin
    goal_c   = ((state == BRAKE) || (tgt.dir != dir)) ? '0 : tgt.duty;
    diff_c   = (goal_c > duty) ? (goal_c - duty) : (duty - goal_c);
    step_c   = (diff_c < STEP_MAX) ? diff_c : STEP_MAX;
    slewed_c = (goal_c > duty) ? (duty + step_c) : (duty - step_c);
  end

  always_comb begin
    state_nxt    = state;
    duty_nxt     = duty;
    dir_nxt      = dir;
    dead_cnt_nxt = dead_cnt;
    if (force_stop) begin
      state_nxt    = IDLE;
      duty_nxt     = '0;
      dead_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tgt.duty != '0) begin
            dead_cnt_nxt = '0;
            state_nxt    = (tgt.dir != dir) ? DEAD : RAMP;
          end
        end
        RAMP: begin
          if (tick) duty_nxt = slewed_c;
          if (tgt.dir != dir)            state_nxt = BRAKE;
          else if (duty_nxt == tgt.duty) state_nxt = (tgt.duty == '0) ? IDLE : RUN;
        end
        RUN: begin
          if (tgt.dir != dir)        state_nxt = BRAKE;
          else if (tgt.duty != duty) state_nxt = RAMP;
        end
        BRAKE: begin
          if (tick) duty_nxt = slewed_c;
          if (duty_nxt == '0) begin
            dead_cnt_nxt = '0;
            state_nxt    = DEAD;
          end
        end
        DEAD: begin
          if (tgt.dir == dir) begin
            state_nxt = RAMP;
          end else if (dead_cnt == DEAD_W'(DEADTIME_CLKS - 1)) begin
            dir_nxt   = tgt.dir;
            state_nxt = RAMP;
          end else begin
            dead_cnt_nxt = dead_cnt + DEAD_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    active_c = (state_nxt == RAMP) || (state_nxt == BRAKE) || (state_nxt == DEAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      duty     <= '0;
      dir      <= 1'b1;
      dead_cnt <= '0;
      applied  <= '0;
      pwm      <= 1'b0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      dir      <= dir_nxt;
      dead_cnt <= dead_cnt_nxt;
      // Comparator copy only follows duty at period start so pulses are never cut short
      if (force_stop)    applied <= '0;
      else if (cnt_wrap) applied <= duty;
      pwm <= !force_stop && (state_nxt != DEAD) && (pwm_cnt < applied);
    end
  end

endmodule

// File: rtl/motor_driver.sv
// Motor command receiver: registers the one-hot command, decodes wheel targets, runs shared ramp/PWM timebases.
module motor_driver
  import motor_pkg::*;
#(
  parameter int unsigned PWM_PRESCALE  = 8,
  parameter int unsigned RAMP_CLKS     = 50000,
  parameter int unsigned RAMP_STEP     = 4,
  parameter int unsigned FULL_DUTY     = FULL_DUTY_DFLT,
  parameter int unsigned TURN_DUTY     = TURN_DUTY_DFLT,
  parameter int unsigned SPIN_DUTY     = SPIN_DUTY_DFLT,
  parameter int unsigned DEADTIME_CLKS = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  motor_state,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic [DUTY_W-1:0] duty_l,
  output logic [DUTY_W-1:0] duty_r,
  output logic              cmd_fault,
  output logic              busy
);

  localparam int unsigned PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int unsigned RAMP_W = (RAMP_CLKS > 1) ? $clog2(RAMP_CLKS) : 1;

  logic [CMD_W-1:0]  cmd_q;
  logic [PRE_W-1:0]  pre_cnt;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              pwm_step_c, cnt_wrap_c, ramp_tick_c, force_stop_c;
  logic              active_l_c, active_r_c;
  ch_target_t        tgt_l_c, tgt_r_c;

  // Illegal commands act on the raw input so the stop lands on the registering edge
  assign force_stop_c = !is_onehot(motor_state);
  assign pwm_step_c   = (pre_cnt == PRE_W'(PWM_PRESCALE - 1));
  assign cnt_wrap_c   = pwm_step_c && (pwm_cnt == '1);
  assign ramp_tick_c  = (ramp_cnt == RAMP_W'(RAMP_CLKS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q     <= CMD_W'(STOP);
      cmd_fault <= 1'b0;
      busy      <= 1'b0;
      pre_cnt   <= '0;
      ramp_cnt  <= '0;
      pwm_cnt   <= '0;
    end else begin
      cmd_q     <= motor_state;
      cmd_fault <= force_stop_c;
      busy      <= active_l_c | active_r_c;
      pre_cnt   <= pwm_step_c ? '0 : (pre_cnt + PRE_W'(1));
      ramp_cnt  <= ramp_tick_c ? '0 : (ramp_cnt + RAMP_W'(1));
      if (pwm_step_c) pwm_cnt <= pwm_cnt + DUTY_W'(1);
    end
  end

  // STOP and illegal codes target zero duty and keep the present direction
  always_comb begin
    tgt_l_c.duty = '0;
    tgt_l_c.dir  = dir_l;
    tgt_r_c.duty = '0;
    tgt_r_c.dir  = dir_r;
    case (cmd_q)
      FORWARD: begin
        tgt_l_c.duty = DUTY_W'(FULL_DUTY); tgt_l_c.dir = 1'b1;
        tgt_r_c.duty = DUTY_W'(FULL_DUTY); tgt_r_c.dir = 1'b1;
      end
      RIGHT: begin
        tgt_l_c.duty = DUTY_W'(FULL_DUTY); tgt_l_c.dir = 1'b1;
        tgt_r_c.duty = DUTY_W'(TURN_DUTY); tgt_r_c.dir = 1'b1;
      end
      LEFT: begin
        tgt_l_c.duty = DUTY_W'(TURN_DUTY); tgt_l_c.dir = 1'b1;
        tgt_r_c.duty = DUTY_W'(FULL_DUTY); tgt_r_c.dir = 1'b1;
      end
      SPIN: begin
        tgt_l_c.duty = DUTY_W'(SPIN_DUTY); tgt_l_c.dir = 1'b1;
        tgt_r_c.duty = DUTY_W'(SPIN_DUTY); tgt_r_c.dir = 1'b0;
      end
      default: ;
    endcase
  end

  motor_channel #(.RAMP_STEP(RAMP_STEP), .DEADTIME_CLKS(DEADTIME_CLKS)) u_left (
    .clk(clk), .reset(reset), .tgt(tgt_l_c), .tick(ramp_tick_c), .pwm_cnt(pwm_cnt),
    .cnt_wrap(cnt_wrap_c), .force_stop(force_stop_c),
    .duty(duty_l), .dir(dir_l), .pwm(pwm_l), .active_c(active_l_c)
  );

  motor_channel #(.RAMP_STEP(RAMP_STEP), .DEADTIME_CLKS(DEADTIME_CLKS)) u_right (
    .clk(clk), .reset(reset), .tgt(tgt_r_c), .tick(ramp_tick_c), .pwm_cnt(pwm_cnt),
    .cnt_wrap(cnt_wrap_c), .force_stop(force_stop_c),
    .duty(duty_r), .dir(dir_r), .pwm(pwm_r), .active_c(active_r_c)
  );

endmodule

// File: tb/tb_motor_driver.sv
// Directed bench for motor_driver: table of settled command responses plus ramp, reversal, fault, PWM and reset sequences.
module tb_motor_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] motor_state;
  logic       pwm_l, pwm_r, dir_l, dir_r, cmd_fault, busy;
  logic [7:0] duty_l, duty_r;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] cmd;
    int clks;
    int duty_l;
    int duty_r;
    int dir_l;
    int dir_r;
    int fault;
    int busy;
  } vec_t;

  vec_t tbl [13];

  // Expected PWM counter phase (prescale 1: one count per clock from reset)
  logic [7:0] m_cnt;

  int n;
  int bad;
  int exp_seq [4];
  int exp_left [4];

  motor_driver #(
    .PWM_PRESCALE(1), .RAMP_CLKS(4), .RAMP_STEP(50), .FULL_DUTY(200),
    .TURN_DUTY(100), .SPIN_DUTY(100), .DEADTIME_CLKS(8)
  ) dut (
    .clk(clk), .reset(reset), .motor_state(motor_state),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .duty_l(duty_l), .duty_r(duty_r), .cmd_fault(cmd_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) m_cnt <= 8'd0;
    else        m_cnt <= m_cnt + 8'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_duty_change(input bit right, input int prev, output int clks);
    int cur;
    clks = 0;
    do begin
      @(negedge clk);
      clks++;
      cur = right ? int'(duty_r) : int'(duty_l);
    end while (cur == prev && clks < 40);
  endtask

  task automatic wait_phase(input int c);
    int k;
    k = 0;
    @(negedge clk);
    while (m_cnt != 8'(c) && k < 600) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Call on the sample with m_cnt==1; i-th sample shows the pulse for counter value i
  task automatic pwm_period(input string tag, input int exp_l, input int exp_r,
                            input int change_at, input logic [4:0] new_cmd);
    int hi_l, hi_r, bad_l, bad_r;
    hi_l = 0; hi_r = 0; bad_l = 0; bad_r = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_l) hi_l++;
      if (pwm_r) hi_r++;
      if (int'(pwm_l) != ((i < exp_l) ? 1 : 0)) bad_l++;
      if (int'(pwm_r) != ((i < exp_r) ? 1 : 0)) bad_r++;
      if (i == change_at) motor_state = new_cmd;
      if (i < 255) @(negedge clk);
    end
    check({tag, " pwm_l high count"}, hi_l, exp_l);
    check({tag, " pwm_r high count"}, hi_r, exp_r);
    check({tag, " pwm_l misplaced samples"}, bad_l, 0);
    check({tag, " pwm_r misplaced samples"}, bad_r, 0);
  endtask

  task automatic check_outputs(input string tag, input int dl, input int dr, input int il,
                               input int ir, input int f, input int b);
    check({tag, " duty_l"}, int'(duty_l), dl);
    check({tag, " duty_r"}, int'(duty_r), dr);
    check({tag, " dir_l"}, int'(dir_l), il);
    check({tag, " dir_r"}, int'(dir_r), ir);
    check({tag, " cmd_fault"}, int'(cmd_fault), f);
    check({tag, " busy"}, int'(busy), b);
  endtask

  initial begin
    tbl[0]  = '{5'b00001, 60, 0,   0,   1, 1, 0, 0};
    tbl[1]  = '{5'b01000, 40, 100, 200, 1, 1, 0, 0};
    tbl[2]  = '{5'b00100, 12, 200, 100, 1, 1, 0, 0};
    tbl[3]  = '{5'b00001, 40, 0,   0,   1, 1, 0, 0};
    tbl[4]  = '{5'b00100, 40, 200, 100, 1, 1, 0, 0};
    tbl[5]  = '{5'b01000, 40, 100, 200, 1, 1, 0, 0};
    tbl[6]  = '{5'b10000, 60, 100, 100, 1, 0, 0, 0};
    tbl[7]  = '{5'b11000, 3,  0,   0,   1, 0, 1, 0};
    tbl[8]  = '{5'b10000, 40, 100, 100, 1, 0, 0, 0};
    tbl[9]  = '{5'b00001, 40, 0,   0,   1, 0, 0, 0};
    tbl[10] = '{5'b00010, 60, 200, 200, 1, 1, 0, 0};
    tbl[11] = '{5'b00000, 2,  0,   0,   1, 1, 1, 0};
    tbl[12] = '{5'b00001, 2,  0,   0,   1, 1, 0, 0};
    exp_seq  = '{50, 100, 150, 200};
    exp_left = '{150, 100, 100, 100};

    reset = 1'b0;
    motor_state = 5'b00001;
    step(3);
    check_outputs("in reset", 0, 0, 1, 1, 0, 0);
    check("in reset pwm_l", int'(pwm_l), 0);
    reset = 1'b1;
    step(5);
    check_outputs("after reset", 0, 0, 1, 1, 0, 0);

    // STOP -> FORWARD soft start
    motor_state = 5'b00010;
    for (int k = 0; k < 4; k++) begin
      wait_duty_change(1'b0, (k == 0) ? 0 : exp_seq[k-1], n);
      check($sformatf("ramp step%0d duty_l", k), int'(duty_l), exp_seq[k]);
      check($sformatf("ramp step%0d duty_r", k), int'(duty_r), exp_seq[k]);
      if (k > 0) check($sformatf("ramp step%0d spacing", k), n, 4);
      if (k == 1) check("ramp busy", int'(busy), 1);
    end
    step(1);
    check("ramp done busy", int'(busy), 0);
    step(2);
    wait_phase(1);
    pwm_period("forward period", 200, 200, -1, 5'b00010);

    // Mid-period duty decrease must not shorten the running pulse
    step(2);
    wait_phase(1);
    pwm_period("mid-period change", 200, 200, 29, 5'b00100);
    check("mid-period duty_r", int'(duty_r), 100);
    @(negedge clk);
    pwm_period("next period", 200, 100, -1, 5'b00100);

    // FORWARD -> SPIN: right brakes, dead time, reverses; left only slows
    motor_state = 5'b00010;
    step(30);
    check("pre-spin duty_r", int'(duty_r), 200);
    motor_state = 5'b10000;
    for (int k = 0; k < 4; k++) begin
      wait_duty_change(1'b1, (k == 0) ? 200 : 200 - 50 * k, n);
      check($sformatf("brake step%0d duty_r", k), int'(duty_r), 150 - 50 * k);
      check($sformatf("brake step%0d duty_l", k), int'(duty_l), exp_left[k]);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (pwm_r !== 1'b0 || dir_r !== 1'b1) bad++;
      @(negedge clk);
    end
    check("dead time pwm_r/dir_r violations", bad, 0);
    check("dir_r after dead time", int'(dir_r), 0);
    wait_duty_change(1'b1, 0, n);
    wait_duty_change(1'b1, 50, n);
    check("spin duty_r", int'(duty_r), 100);
    check("spin duty_l", int'(duty_l), 100);
    check("spin dir_l", int'(dir_l), 1);

    // Illegal command while running
    motor_state = 5'b00110;
    @(negedge clk);
    check("illegal cmd_fault", int'(cmd_fault), 1);
    check("illegal duty_l", int'(duty_l), 0);
    check("illegal duty_r", int'(duty_r), 0);
    check("illegal pwm_l", int'(pwm_l), 0);
    check("illegal pwm_r", int'(pwm_r), 0);
    motor_state = 5'b00010;
    @(negedge clk);
    check("recover cmd_fault", int'(cmd_fault), 0);
    check("recover duty_l", int'(duty_l), 0);
    wait_duty_change(1'b0, 0, n);
    check("recover first step duty_l", int'(duty_l), 50);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_outputs("recover settled", 200, 200, 1, 1, 0, 0);

    for (int i = 0; i < 13; i++) begin
      motor_state = tbl[i].cmd;
      step(tbl[i].clks);
      check_outputs($sformatf("row%0d", i), tbl[i].duty_l, tbl[i].duty_r,
                    tbl[i].dir_l, tbl[i].dir_r, tbl[i].fault, tbl[i].busy);
    end

    // Asynchronous reset between clock edges
    motor_state = 5'b00010;
    step(30);
    check("pre-reset duty_l", int'(duty_l), 200);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_outputs("async reset fwd", 0, 0, 1, 1, 0, 0);
    check("async reset pwm_l", int'(pwm_l), 0);
    check("async reset pwm_r", int'(pwm_r), 0);
    motor_state = 5'b10000;
    @(negedge clk);
    reset = 1'b1;
    step(60);
    check("pre-reset dir_r", int'(dir_r), 0);
    #2 reset = 1'b0;
    #1;
    check_outputs("async reset spin", 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
